// File: rtl/norm_share_arbiter_if.sv
// Bus bundle for the shared product normalizer: two operand requesters
// plus one valid/ready result channel.
interface norm_share_arbiter_if #(
  parameter int PW = 106,
  parameter int EW = 11,
  parameter int MW = 52
);
  logic          req0_valid;
  logic          req0_ready;
  logic [PW-1:0] req0_prod;
  logic [EW-1:0] req0_exp;
  logic          req0_sign;

  logic          req1_valid;
  logic          req1_ready;
  logic [PW-1:0] req1_prod;
  logic [EW-1:0] req1_exp;
  logic          req1_sign;

  logic          out_valid;
  logic          out_ready;
  logic          out_id;
  logic [MW-1:0] out_mant;
  logic [EW-1:0] out_exp;
  logic          out_sign;
  logic          out_ovf;

  modport slave (
    input  req0_valid, req0_prod, req0_exp, req0_sign,
    input  req1_valid, req1_prod, req1_exp, req1_sign,
    output req0_ready, req1_ready,
    output out_valid, out_id, out_mant, out_exp, out_sign, out_ovf,
    input  out_ready
  );

  modport master (
    output req0_valid, req0_prod, req0_exp, req0_sign,
    output req1_valid, req1_prod, req1_exp, req1_sign,
    input  req0_ready, req1_ready,
    input  out_valid, out_id, out_mant, out_exp, out_sign, out_ovf,
    output out_ready
  );
endinterface

// File: rtl/norm_share_arbiter.sv
// Round-robin share of one registered product normalizer between two
// Vedic mantissa-multiply paths, with per-requester accept counters.
module norm_share_arbiter #(
  parameter int PW = 106,
  parameter int EW = 11,
  parameter int MW = 52,
  parameter int CW = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  norm_share_arbiter_if.slave  bus,
  output logic [CW-1:0]        acc_cnt0,
  output logic [CW-1:0]        acc_cnt1
);

  localparam int NW = MW + EW + 1;

  // Result packed as {ovf, exp, mant}; exponent carried one bit wider so
  // the wrap out of the top is visible as overflow.
  function automatic logic [NW-1:0] normalize(input logic [PW-1:0] p,
                                              input logic [EW-1:0] e_in);
    logic [EW:0]   e;
    logic [MW-1:0] m;
    logic          ovf;
    if (p[PW-1]) begin
      m = p[PW-2 -: MW];
      e = {1'b0, e_in} + {{EW{1'b0}}, 1'b1};
    end else begin
      m = p[PW-3 -: MW];
      e = {1'b0, e_in};
    end
    ovf = e[EW] | (&e[EW-1:0]);
    return {ovf, e[EW-1:0], m};
  endfunction

  logic          out_valid_q, out_valid_d;
  logic          out_id_q,    out_id_d;
  logic [MW-1:0] out_mant_q,  out_mant_d;
  logic [EW-1:0] out_exp_q,   out_exp_d;
  logic          out_sign_q,  out_sign_d;
  logic          out_ovf_q,   out_ovf_d;
  logic          prio_q,      prio_d;
  logic [CW-1:0] acc_cnt0_q,  acc_cnt0_d;
  logic [CW-1:0] acc_cnt1_q,  acc_cnt1_d;

  logic          adv;
  logic          grant0;
  logic          grant1;
  logic          accept;
  logic [PW-1:0] sel_prod;
  logic [EW-1:0] sel_exp;
  logic          sel_sign;
  logic [NW-1:0] norm;

  assign adv    = !out_valid_q | bus.out_ready;
  assign grant0 = bus.req0_valid & (!bus.req1_valid | !prio_q);
  assign grant1 = bus.req1_valid & (!bus.req0_valid |  prio_q);
  assign accept = adv & (bus.req0_valid | bus.req1_valid) & !rst;

  assign bus.req0_ready = adv & grant0 & !rst;
  assign bus.req1_ready = adv & grant1 & !rst;

  assign sel_prod = grant1 ? bus.req1_prod : bus.req0_prod;
  assign sel_exp  = grant1 ? bus.req1_exp  : bus.req0_exp;
  assign sel_sign = grant1 ? bus.req1_sign : bus.req0_sign;
  assign norm     = normalize(sel_prod, sel_exp);

  always_comb begin
    out_valid_d = out_valid_q;
    out_id_d    = out_id_q;
    out_mant_d  = out_mant_q;
    out_exp_d   = out_exp_q;
    out_sign_d  = out_sign_q;
    out_ovf_d   = out_ovf_q;
    prio_d      = prio_q;
    acc_cnt0_d  = acc_cnt0_q;
    acc_cnt1_d  = acc_cnt1_q;
    if (accept) begin
      out_valid_d = 1'b1;
      out_id_d    = grant1;
      out_mant_d  = norm[MW-1:0];
      out_exp_d   = norm[MW +: EW];
      out_ovf_d   = norm[NW-1];
      out_sign_d  = sel_sign;
      // Favour the loser next time so a contested pair alternates.
      prio_d      = !grant1;
      if (grant1) acc_cnt1_d = acc_cnt1_q + {{(CW-1){1'b0}}, 1'b1};
      else        acc_cnt0_d = acc_cnt0_q + {{(CW-1){1'b0}}, 1'b1};
    end else if (adv) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_id_q    <= 1'b0;
      out_mant_q  <= '0;
      out_exp_q   <= '0;
      out_sign_q  <= 1'b0;
      out_ovf_q   <= 1'b0;
      prio_q      <= 1'b0;
      acc_cnt0_q  <= '0;
      acc_cnt1_q  <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_id_q    <= out_id_d;
      out_mant_q  <= out_mant_d;
      out_exp_q   <= out_exp_d;
      out_sign_q  <= out_sign_d;
      out_ovf_q   <= out_ovf_d;
      prio_q      <= prio_d;
      acc_cnt0_q  <= acc_cnt0_d;
      acc_cnt1_q  <= acc_cnt1_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_id    = out_id_q;
  assign bus.out_mant  = out_mant_q;
  assign bus.out_exp   = out_exp_q;
  assign bus.out_sign  = out_sign_q;
  assign bus.out_ovf   = out_ovf_q;
  assign acc_cnt0      = acc_cnt0_q;
  assign acc_cnt1      = acc_cnt1_q;

endmodule

// File: tb/tb_norm_share_arbiter.sv
// Scoreboard bench for norm_share_arbiter: directed operands with
// hand-computed normalized results, arbitration order and counters.
module tb_norm_share_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] acc_cnt0;
  logic [15:0] acc_cnt1;

  norm_share_arbiter_if #(.PW(106), .EW(11), .MW(52)) bus_if ();

  norm_share_arbiter #(.PW(106), .EW(11), .MW(52), .CW(16)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus_if.slave),
    .acc_cnt0 (acc_cnt0),
    .acc_cnt1 (acc_cnt1)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        id;
    logic [51:0] mant;
    logic [10:0] exp;
    logic        sign;
    logic        ovf;
  } res_t;

  res_t q[$];
  res_t want0, want1;
  int   total = 0;
  int   bad   = 0;
  logic m_ov   = 1'b0;
  logic m_prio = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp_v);
    total++;
    if (act !== exp_v) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp_v);
    end
  endtask

  task automatic set_req(input int n, input logic v, input logic [105:0] prod,
                         input logic [10:0] e, input logic s,
                         input logic [51:0] w_mant, input logic [10:0] w_exp,
                         input logic w_ovf);
    if (n == 0) begin
      bus_if.req0_valid = v; bus_if.req0_prod = prod;
      bus_if.req0_exp = e;   bus_if.req0_sign = s;
      want0 = '{id: 1'b0, mant: w_mant, exp: w_exp, sign: s, ovf: w_ovf};
    end else begin
      bus_if.req1_valid = v; bus_if.req1_prod = prod;
      bus_if.req1_exp = e;   bus_if.req1_sign = s;
      want1 = '{id: 1'b1, mant: w_mant, exp: w_exp, sign: s, ovf: w_ovf};
    end
  endtask

  // One clock: predict readys, check them, record the expected result of
  // any accept, then advance past the rising edge.
  task automatic step();
    logic v0, v1, adv, g0, g1;
    @(negedge clk);
    v0  = bus_if.req0_valid;
    v1  = bus_if.req1_valid;
    adv = !m_ov | bus_if.out_ready;
    g0  = v0 & (!v1 | !m_prio) & !rst;
    g1  = v1 & (!v0 |  m_prio) & !rst;
    check("req0_ready", {63'd0, bus_if.req0_ready}, {63'd0, adv & g0});
    check("req1_ready", {63'd0, bus_if.req1_ready}, {63'd0, adv & g1});
    if (rst) begin
      m_ov = 1'b0; m_prio = 1'b0;
      q.delete();
    end else if (adv) begin
      if (g0) begin q.push_back(want0); m_prio = 1'b1; end
      if (g1) begin q.push_back(want1); m_prio = 1'b0; end
      m_ov = g0 | g1;
    end
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (!rst && bus_if.out_valid && bus_if.out_ready) begin
      res_t e;
      if (q.size() == 0) begin
        total++; bad++;
        $display("FAIL out_unexpected: got result id=%0d with nothing expected", bus_if.out_id);
      end else begin
        e = q.pop_front();
        check("out_id",   {63'd0, bus_if.out_id},   {63'd0, e.id});
        check("out_mant", {12'd0, bus_if.out_mant}, {12'd0, e.mant});
        check("out_exp",  {53'd0, bus_if.out_exp},  {53'd0, e.exp});
        check("out_sign", {63'd0, bus_if.out_sign}, {63'd0, e.sign});
        check("out_ovf",  {63'd0, bus_if.out_ovf},  {63'd0, e.ovf});
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus_if.out_ready = 1'b1;
    set_req(0, 1'b1, {1'b1, 52'h1, 53'd0}, 11'h001, 1'b0, 52'h1, 11'h002, 1'b0);
    set_req(1, 1'b1, {1'b1, 52'h2, 53'd0}, 11'h001, 1'b1, 52'h2, 11'h002, 1'b0);

    // Reset with both requesters valid
    rst = 1'b1;
    step();
    step();
    check("rst_out_valid", {63'd0, bus_if.out_valid}, 64'd0);
    check("rst_out_id",    {63'd0, bus_if.out_id},    64'd0);
    check("rst_out_mant",  {12'd0, bus_if.out_mant},  64'd0);
    check("rst_out_exp",   {53'd0, bus_if.out_exp},   64'd0);
    check("rst_out_sign",  {63'd0, bus_if.out_sign},  64'd0);
    check("rst_out_ovf",   {63'd0, bus_if.out_ovf},   64'd0);
    check("rst_cnt0",      {48'd0, acc_cnt0},         64'd0);
    check("rst_cnt1",      {48'd0, acc_cnt1},         64'd0);
    rst = 1'b0;
    set_req(0, 1'b0, '0, '0, 1'b0, '0, '0, 1'b0);
    set_req(1, 1'b0, '0, '0, 1'b0, '0, '0, 1'b0);

    // Shift path, no-shift path, overflows, unnormalized 00 case
    set_req(0, 1'b1, {1'b1, 52'hABCDEF0123456, 53'd0}, 11'h3FF, 1'b0,
            52'hABCDEF0123456, 11'h400, 1'b0);
    step();
    check("lat_out_valid", {63'd0, bus_if.out_valid}, 64'd1);
    bus_if.req0_valid = 1'b0;
    set_req(1, 1'b1, {2'b01, 52'h1, 52'd0}, 11'h7FE, 1'b1, 52'h1, 11'h7FE, 1'b0);
    step();
    set_req(1, 1'b1, {1'b1, 52'hFFFFFFFFFFFFF, 53'd0}, 11'h7FE, 1'b0,
            52'hFFFFFFFFFFFFF, 11'h7FF, 1'b1);
    step();
    set_req(1, 1'b1, {1'b1, 52'h0000000000003, 53'd0}, 11'h7FF, 1'b1,
            52'h3, 11'h000, 1'b1);
    step();
    bus_if.req1_valid = 1'b0;
    set_req(0, 1'b1, {2'b00, 52'h5, 52'hFFFFFFFFFFFFF}, 11'h123, 1'b1, 52'h5, 11'h123, 1'b0);
    step();
    bus_if.req0_valid = 1'b0;
    step();
    step();
    check("idle_out_valid", {63'd0, bus_if.out_valid}, 64'd0);
    check("dir_cnt0", {48'd0, acc_cnt0}, 64'd2);
    check("dir_cnt1", {48'd0, acc_cnt1}, 64'd3);

    // Contention from a fresh reset: strict alternation 0,1,0,1,0,1
    rst = 1'b1;
    step();
    rst = 1'b0;
    set_req(0, 1'b1, {1'b1, 52'h111, 53'd0}, 11'h100, 1'b0, 52'h111, 11'h101, 1'b0);
    set_req(1, 1'b1, {2'b01, 52'h222, 52'd0}, 11'h200, 1'b1, 52'h222, 11'h200, 1'b0);
    for (int i = 0; i < 6; i++) step();
    check("cont_cnt0", {48'd0, acc_cnt0}, 64'd3);
    check("cont_cnt1", {48'd0, acc_cnt1}, 64'd3);

    // Backpressure: result from req1 held, no grants, prio held
    bus_if.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("hold_valid", {63'd0, bus_if.out_valid}, 64'd1);
      check("hold_id",    {63'd0, bus_if.out_id},    64'd1);
      check("hold_mant",  {12'd0, bus_if.out_mant},  64'h222);
      check("hold_exp",   {53'd0, bus_if.out_exp},   64'h200);
      check("hold_cnt0",  {48'd0, acc_cnt0},         64'd3);
    end
    bus_if.out_ready = 1'b1;
    step();
    check("bp_regrant_id", {63'd0, bus_if.out_id}, 64'd0);
    check("bp_cnt0", {48'd0, acc_cnt0}, 64'd4);
    bus_if.req0_valid = 1'b0;
    bus_if.req1_valid = 1'b0;
    step();
    step();

    // Counter wrap on requester 0
    rst = 1'b1;
    step();
    rst = 1'b0;
    set_req(0, 1'b1, '0, '0, 1'b0, '0, '0, 1'b0);
    for (int i = 0; i < 65535; i++) step();
    check("wrap_cnt0_max", {48'd0, acc_cnt0}, 64'hFFFF);
    step();
    check("wrap_cnt0_zero", {48'd0, acc_cnt0}, 64'd0);
    check("wrap_cnt1", {48'd0, acc_cnt1}, 64'd0);
    bus_if.req0_valid = 1'b0;
    step();
    step();
    check("sb_drain", 64'(q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
